mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles to wait for a bus grant or response before aborting.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ex_mem_valid_i  input  1  ex_mem_data_i holds a real instruction.
REQ-005 SHALL have port ex_mem_data_i  input  ex_mem_data_t  execute output; fields used: alu_result, write_data, mem_write, result_src (2'b01 = load), funct3, rd_addr, reg_write, pc_plus_4.
REQ-006 SHALL have port dmem_req_o  output  1  bus request.
REQ-007 SHALL have port dmem_we_o  output  1  1 = store.
REQ-008 SHALL have port dmem_addr_o  output  32  word-aligned address (alu_result with bits [1:0] forced to 0).
REQ-009 SHALL have port dmem_wdata_o  output  32  lane-replicated store data.
REQ-010 SHALL have port dmem_be_o  output  4  byte enables.
REQ-011 SHALL have port dmem_gnt_i  input  1  request accepted this cycle.
REQ-012 SHALL have port dmem_rvalid_i  input  1  read data valid.
REQ-013 SHALL have port dmem_rdata_i  input  32  read data word.
REQ-014 SHALL have port mem_wb_data_o  output  mem_wb_data_t  registered result to writeback: read_data, alu_result, rd_addr, reg_write, result_src, pc_plus_4.
REQ-015 SHALL have port mem_wb_valid_o  output  1  mem_wb_data_o holds a completed instruction.
REQ-016 SHALL have port stall_o  output  1  combinational; upstream holds its inputs stable while it is high.
REQ-017 SHALL have port mem_err_o  output  1  one-cycle pulse on an aborted access.

Function
REQ-018 SHALL implement FSM IDLE/REQ/RSP: IDLE accepts ops; REQ holds request until grant; RSP awaits rvalid.
REQ-019 SHALL, for a valid non-memory op in IDLE, register it into mem_wb_data_o at the next edge with mem_wb_valid_o=1, no bus request, and stall_o=0.
REQ-020 SHALL, for a valid memory op in IDLE, drive dmem_req_o combinationally in that same cycle; without a grant it moves to REQ.
REQ-021 SHALL hold dmem_req_o, addr, we, be, and wdata stable in REQ until dmem_gnt_i.
REQ-022 SHALL complete a granted store in its grant cycle; a granted load moves to RSP, and rvalid is accepted no earlier than the cycle after grant.
REQ-023 SHALL, in RSP on dmem_rvalid_i, capture the extracted data, write mem_wb at the next edge, and return to IDLE.
REQ-024 SHALL drive stall_o=1 whenever a memory op is pending, and 0 in the completion cycle (store grant, load rvalid, or abort).
REQ-025 SHALL generate byte enables from funct3: 000 = 4'b0001<<addr[1:0]; 001 = 4'b0011<<{addr[1],1'b0}; 010 = 4'b1111.
REQ-026 SHALL replicate store data: byte x4, halfword x2, word as-is.
REQ-027 SHALL extract load data by shifting rdata right 8*addr[1:0], then extend: LB/LH sign-extend, LBU(100)/LHU(101) zero-extend, LW pass-through.
REQ-028 SHALL drive mem_wb_valid_o=0 and mem_wb reg_write=0 in any cycle following no completion (stall, or bubble with ex_mem_valid_i=0).
REQ-029 SHALL run a timeout counter that clears on entry to REQ/RSP and increments each cycle there; on reaching TIMEOUT_CYCLES it drops the request, pulses mem_err_o, emits mem_wb_valid_o=1 with reg_write=0, and returns to IDLE.
REQ-030 SHALL ignore dmem_rvalid_i in IDLE and REQ.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state IDLE, counter 0, and every output 0 (including all mem_wb_data_o fields), even mid-access.

Configuration
REQ-032 SHALL, with MEM_MISALIGN_CHECK_EN defined, treat a halfword op with addr[0]=1 or a word op with addr[1:0]!=0 as misaligned: no bus request, stall_o=0, next edge mem_err_o=1 and mem_wb_valid_o=1 with reg_write=0; without the macro, it SHALL issue the access using only the lane bits of REQ-025 (halfword ignores addr[0], word ignores addr[1:0]).

Verification
REQ-033 SHALL verify: ALU op alu_result=0x1234, rd=5, reg_write=1 -> next edge mem_wb_valid_o=1, alu_result=0x1234, dmem_req_o never 1.
REQ-034 SHALL verify: SB addr 0x1003, write_data 0xAB, grant same cycle -> addr 0x1000, be 4'b1000, wdata 0xABABABAB, stall_o=0, valid next edge.
REQ-035 SHALL verify: LH addr 0x2002, grant after 2 cycles, rvalid 1 cycle later with rdata 0x8001_0000 -> read_data 0xFFFF8001, stall_o high until the rvalid cycle; the same sequence as LHU -> read_data 0x00008001.
REQ-036 SHALL verify: load with TIMEOUT_CYCLES=4 and rvalid never asserted -> mem_err_o pulse after 4 RSP cycles, reg_write=0, and the following ALU op completes normally.
REQ-037 SHALL verify: rst_n low during RSP -> dmem_req_o and stall_o 0 immediately, and after release an ALU op completes.
REQ-038 SHALL verify: LW at 0x3001 -> with macro, no request and mem_err_o=1; without macro, request to 0x3000 with be 4'b1111.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store stage between execute and writeback.
// Issues one data-bus access per memory instruction (request/grant, then
// read response for loads), forms byte enables and lane-replicated store
// data, extracts and extends load data, and aborts an access that waits
// TIMEOUT_CYCLES cycles for the bus.
// Optional build macro MEM_MISALIGN_CHECK_EN: flag misaligned halfword/word
// accesses as errors instead of issuing them.

package mem_stage_pkg;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic [31:0] pc_plus_4;
    } ex_mem_data_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] pc_plus_4;
    } mem_wb_data_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_mem_valid_i,
    input  ex_mem_data_t ex_mem_data_i,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output logic [31:0]  dmem_addr_o,
    output logic [31:0]  dmem_wdata_o,
    output logic [3:0]   dmem_be_o,
    input  logic         dmem_gnt_i,
    input  logic         dmem_rvalid_i,
    input  logic [31:0]  dmem_rdata_i,
    output mem_wb_data_t mem_wb_data_o,
    output logic         mem_wb_valid_o,
    output logic         stall_o,
    output logic         mem_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    ex_mem_data_t op_q;
    ex_mem_data_t op;
    logic [CNT_W-1:0] cnt_q;

    logic        is_store, is_load, is_mem;
    logic [1:0]  addr_lo, size;
    logic [1:0]  lane_off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        misaligned;
    logic        timeout;

    logic req, stall, complete, abort, capture;

    // In IDLE the op comes straight from execute; once an access is under
    // way the captured copy is used so bus fields cannot move.
    assign op       = (state_q == S_IDLE) ? ex_mem_data_i : op_q;
    assign is_store = op.mem_write;
    assign is_load  = !op.mem_write && (op.result_src == RESULT_SRC_LOAD);
    assign is_mem   = is_store || is_load;
    assign addr_lo  = op.alu_result[1:0];
    assign size     = op.funct3[1:0];
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = is_mem && (((size == 2'b01) && addr_lo[0]) ||
                                   (size[1] && (addr_lo != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Lane selection: byte enables, replicated store data, lane offset.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        lane_off = 2'b00;
        be_c     = 4'b1111;
        wdata_c  = op.write_data;
        case (size)
            2'b00: begin
                lane_off = addr_lo;
                be_c     = 4'b0001 << addr_lo;
                wdata_c  = {4{op.write_data[7:0]}};
            end
            2'b01: begin
                lane_off = {addr_lo[1], 1'b0};
                be_c     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_c  = {2{op.write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        shifted  = dmem_rdata_i >> {lane_off, 3'b000};
        load_ext = shifted;
        case (op.funct3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Next-state and control decode; everything is held low during reset.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (ex_mem_valid_i) begin
                        if (!is_mem) begin
                            complete = 1'b1;
                        end else if (misaligned) begin
                            abort = 1'b1;
                        end else begin
                            req = 1'b1;
                            if (dmem_gnt_i && is_store) begin
                                complete = 1'b1;
                            end else begin
                                stall   = 1'b1;
                                state_d = dmem_gnt_i ? S_RSP : S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (timeout) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        req = 1'b1;
                        if (dmem_gnt_i && is_store) begin
                            complete = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            stall = 1'b1;
                            if (dmem_gnt_i) state_d = S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (timeout) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end else if (dmem_rvalid_i) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign capture      = (state_q == S_IDLE) && (state_d != S_IDLE);
    assign stall_o      = stall;
    assign dmem_req_o   = req;
    assign dmem_we_o    = req && is_store;
    assign dmem_addr_o  = req ? {op.alu_result[31:2], 2'b00} : 32'b0;
    assign dmem_be_o    = req ? be_c : 4'b0;
    assign dmem_wdata_o = (req && is_store) ? wdata_c : 32'b0;

    // State register, captured op, and wait counter (cleared on each state entry).
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) op_q <= ex_mem_data_i;
            if ((state_d != S_IDLE) && (state_d == state_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Writeback register: completed ops, aborts (no register write), else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_data_o  <= '0;
            mem_wb_valid_o <= 1'b0;
            mem_err_o      <= 1'b0;
        end else begin
            mem_wb_valid_o <= complete || abort;
            mem_err_o      <= abort;
            if (complete || abort) begin
                mem_wb_data_o.read_data  <= (complete && is_load) ? load_ext : 32'b0;
                mem_wb_data_o.alu_result <= op.alu_result;
                mem_wb_data_o.rd_addr    <= op.rd_addr;
                mem_wb_data_o.reg_write  <= complete && op.reg_write;
                mem_wb_data_o.result_src <= op.result_src;
                mem_wb_data_o.pc_plus_4  <= op.pc_plus_4;
            end else begin
                mem_wb_data_o.reg_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized ops, checked by a
// scoreboard fed from a spec-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ex_mem_valid_i;
    ex_mem_data_t ex_mem_data_i;
    logic         dmem_req_o, dmem_we_o;
    logic [31:0]  dmem_addr_o, dmem_wdata_o;
    logic [3:0]   dmem_be_o;
    logic         dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]  dmem_rdata_i;
    mem_wb_data_t mem_wb_data_o;
    logic         mem_wb_valid_o, stall_o, mem_err_o;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid_i(ex_mem_valid_i), .ex_mem_data_i(ex_mem_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_wb_data_o(mem_wb_data_o), .mem_wb_valid_o(mem_wb_valid_o),
        .stall_o(stall_o), .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] read_data;
        bit          chk_rd;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] pc4;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] addr);
        int n = size_bytes(f3);
        return (int'(addr[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int n = size_bytes(f3);
        int lane = lane_of(f3, addr);
        for (int i = 0; i < 4; i++) be[i] = (i >= lane) && (i < lane + n);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int n = size_bytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v = 32'b0;
        int n = size_bytes(f3);
        int lane = lane_of(f3, addr);
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(lane+k) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic bit model_misaligned(input ex_mem_data_t op);
`ifdef MEM_MISALIGN_CHECK_EN
        int n = size_bytes(op.funct3);
        bit mem = op.mem_write || (op.result_src == 2'b01);
        return mem && ((n == 2 && op.alu_result[0]) || (n == 4 && op.alu_result[1:0] != 2'b00));
`else
        return (op.alu_result === 32'hx);
`endif
    endfunction

    function automatic ex_mem_data_t mk_op(input logic [31:0] alu, input logic [31:0] wd,
                                           input logic mw, input logic [1:0] rs,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic rw);
        ex_mem_data_t op;
        op.alu_result = alu;  op.write_data = wd;  op.mem_write = mw;
        op.result_src = rs;   op.funct3 = f3;      op.rd_addr = rd;
        op.reg_write  = rw;   op.pc_plus_4 = $urandom();
        return op;
    endfunction

    function automatic void push_exp(input ex_mem_data_t op, input logic [31:0] rdv,
                                     input bit chk_rd, input bit err);
        exp_t e;
        e.read_data = rdv;  e.chk_rd = chk_rd && !err;
        e.alu = op.alu_result;  e.rd = op.rd_addr;  e.rs = op.result_src;
        e.pc4 = op.pc_plus_4;   e.rw = err ? 1'b0 : op.reg_write;
        e.err = err;  e.due = cyc + 1;
        sb.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clk) begin
        if (mem_wb_valid_o) begin
            check("wb_expected", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("wb_latency", cyc, got.due);
                check("wb_err", mem_err_o, got.err);
                check("wb_reg_write", mem_wb_data_o.reg_write, got.rw);
                if (!got.err) begin
                    check("wb_alu", mem_wb_data_o.alu_result, got.alu);
                    check("wb_rd", mem_wb_data_o.rd_addr, got.rd);
                    check("wb_rs", mem_wb_data_o.result_src, got.rs);
                    check("wb_pc4", mem_wb_data_o.pc_plus_4, got.pc4);
                end
                if (got.chk_rd) check("wb_read_data", mem_wb_data_o.read_data, got.read_data);
            end
        end else begin
            if (mem_err_o) check("err_without_valid", mem_err_o, 1'b0);
            if (mem_wb_data_o.reg_write) check("bubble_reg_write", mem_wb_data_o.reg_write, 1'b0);
        end
    end

    // ---------------- driver ----------------
    // Entered and left just after a rising edge.
    task automatic run_op(input ex_mem_data_t op, input int gnt_dly, input int rv_dly,
                          input bit hang, input logic [31:0] rdata);
        bit is_store = op.mem_write;
        bit is_load  = !op.mem_write && (op.result_src == 2'b01);
        bit misal    = model_misaligned(op);
        int last;
        ex_mem_valid_i = 1'b1;
        ex_mem_data_i  = op;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        if (!(is_store || is_load) || misal) begin
            dmem_rvalid_i = 1'($urandom_range(0, 1));
            dmem_rdata_i  = $urandom();
            @(negedge clk);
            check("noreq_req", dmem_req_o, 1'b0);
            check("noreq_stall", stall_o, 1'b0);
            push_exp(op, 32'b0, 1'b0, misal);
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
            return;
        end
        for (int c = 0; c <= gnt_dly; c++) begin
            dmem_gnt_i    = (c == gnt_dly);
            dmem_rvalid_i = 1'($urandom_range(0, 1));
            dmem_rdata_i  = $urandom();
            @(negedge clk);
            check("req_req", dmem_req_o, 1'b1);
            check("req_we", dmem_we_o, is_store);
            check("req_addr", dmem_addr_o, {op.alu_result[31:2], 2'b00});
            check("req_be", dmem_be_o, model_be(op.funct3, op.alu_result));
            if (is_store) check("req_wdata", dmem_wdata_o, model_wdata(op.funct3, op.write_data));
            check("req_stall", stall_o, !(is_store && c == gnt_dly));
            if (is_store && c == gnt_dly) push_exp(op, 32'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (is_store) return;
        last = hang ? T : rv_dly;
        for (int r = 1; r <= last; r++) begin
            dmem_rvalid_i = !hang && (r == rv_dly);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom();
            @(negedge clk);
            check("rsp_req", dmem_req_o, 1'b0);
            check("rsp_stall", stall_o, r < last);
            if (r == last) push_exp(op, model_load(op.funct3, op.alu_result, rdata), 1'b1, hang);
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            ex_mem_valid_i = 1'b0;
            ex_mem_data_i  = mk_op($urandom(), $urandom(), 1'b1, 2'b01, 3'b010, 5'd3, 1'b1);
            dmem_gnt_i     = 1'($urandom_range(0, 1));
            dmem_rvalid_i  = 1'($urandom_range(0, 1));
            dmem_rdata_i   = $urandom();
            @(negedge clk);
            check("bubble_req", dmem_req_o, 1'b0);
            check("bubble_stall", stall_o, 1'b0);
            @(posedge clk); #1;
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_mem_data_t op;
        // Reset with a valid memory op and bus activity on the inputs.
        rst_n          = 1'b0;
        ex_mem_valid_i = 1'b1;
        ex_mem_data_i  = mk_op(32'h0000_0104, 32'h1122_3344, 1'b1, 2'b00, 3'b010, 5'd7, 1'b1);
        dmem_gnt_i     = 1'b1;
        dmem_rvalid_i  = 1'b1;
        dmem_rdata_i   = 32'hDEAD_BEEF;
        #2;
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_we", dmem_we_o, 1'b0);
        check("rst_addr", dmem_addr_o, 32'b0);
        check("rst_be", dmem_be_o, 4'b0);
        check("rst_wdata", dmem_wdata_o, 32'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_valid", mem_wb_valid_o, 1'b0);
        check("rst_err", mem_err_o, 1'b0);
        check("rst_wb_alu", mem_wb_data_o.alu_result, 32'b0);
        check("rst_wb_rdata", mem_wb_data_o.read_data, 32'b0);
        check("rst_wb_pc4", mem_wb_data_o.pc_plus_4, 32'b0);
        check("rst_wb_misc", {mem_wb_data_o.rd_addr, mem_wb_data_o.reg_write, mem_wb_data_o.result_src}, 32'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bubble(1);

        // ALU op.
        run_op(mk_op(32'h0000_1234, 32'h0, 1'b0, 2'b00, 3'b000, 5'd5, 1'b1), 0, 1, 1'b0, 32'h0);
        bubble(1);
        // SB to 0x1003 granted immediately.
        run_op(mk_op(32'h0000_1003, 32'h0000_00AB, 1'b1, 2'b00, 3'b000, 5'd0, 1'b0), 0, 1, 1'b0, 32'h0);
        bubble(1);
        // LH / LHU at 0x2002, grant after 2 cycles, rvalid one cycle later.
        run_op(mk_op(32'h0000_2002, 32'h0, 1'b0, 2'b01, 3'b001, 5'd9, 1'b1), 2, 1, 1'b0, 32'h8001_0000);
        run_op(mk_op(32'h0000_2002, 32'h0, 1'b0, 2'b01, 3'b101, 5'd10, 1'b1), 2, 1, 1'b0, 32'h8001_0000);
        bubble(1);
        // Load whose response never arrives, then an ALU op.
        run_op(mk_op(32'h0000_0040, 32'h0, 1'b0, 2'b01, 3'b010, 5'd11, 1'b1), 0, 1, 1'b1, 32'h0);
        run_op(mk_op(32'h0000_5555, 32'h0, 1'b0, 2'b00, 3'b000, 5'd12, 1'b1), 0, 1, 1'b0, 32'h0);
        bubble(1);
        // LW at 0x3001.
        run_op(mk_op(32'h0000_3001, 32'h0, 1'b0, 2'b01, 3'b010, 5'd13, 1'b1), 0, 1, 1'b0, 32'hCAFE_F00D);
        bubble(1);

        // Reset asserted while waiting for a read response.
        op = mk_op(32'h0000_0500, 32'h0, 1'b0, 2'b01, 3'b010, 5'd14, 1'b1);
        ex_mem_valid_i = 1'b1;
        ex_mem_data_i  = op;
        dmem_gnt_i     = 1'b1;
        @(negedge clk);
        check("rstmid_req_before", dmem_req_o, 1'b1);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        check("rstmid_stall_rsp", stall_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_req", dmem_req_o, 1'b0);
        check("rstmid_stall", stall_o, 1'b0);
        check("rstmid_valid", mem_wb_valid_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bubble(1);
        run_op(mk_op(32'h0000_0777, 32'h0, 1'b0, 2'b10, 3'b000, 5'd15, 1'b1), 0, 1, 1'b0, 32'h0);
        bubble(1);

        // Randomized mix of ALU, store and load ops.
        for (int i = 0; i < 150; i++) begin
            int kind = $urandom_range(0, 2);
            int idx;
            logic [2:0] f3;
            logic [31:0] a;
            bit hang = 1'b0;
            a = $urandom();
            if (kind == 0) begin
                op = mk_op(a, $urandom(), 1'b0, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                           3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                if (kind == 1) begin
                    f3 = 3'($urandom_range(0, 2));
                end else begin
                    idx = $urandom_range(0, 4);
                    f3  = 3'((idx < 3) ? idx : idx + 1);
                    hang = ($urandom_range(0, 19) == 0);
                end
                a = a & ~32'(size_bytes(f3) - 1);
                op = mk_op(a, $urandom(), kind == 1, (kind == 2) ? 2'b01 : 2'b00, f3,
                           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            run_op(op, $urandom_range(0, 3), $urandom_range(1, 3), hang, $urandom());
            bubble($urandom_range(0, 2));
        end

        bubble(3);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
